risc_v_32_stall_pipe: RTL

Front-end pipeline register block of the RV32IM core. It holds the PC, the IF/ID register and the ID/EX control/rd register, and executes the hazard unit's decisions: PC hold, IF/ID hold, and bubble injection through the muxed decode vector. It also handles branch/jump flush. It feeds ifid_rs1/ifid_rs2/idex_rd/idex_memread back to the hazard unit and keeps stall/flush performance counters.

---
 rtl/risc_v_32_stall_pipe.sv | 82 ++++++++
 1 files changed

// File: rtl/risc_v_32_stall_pipe.sv
// risc_v_32_stall_pipe: PC, IF/ID and ID/EX registers with stall, bubble and flush handling
module risc_v_32_stall_pipe #(
    parameter logic [31:0]       RESET_PC  = 32'h0000_0000,
    parameter int                CTRL_W    = 37,
    parameter logic [CTRL_W-1:0] LOAD_MASK = 37'h0_0000_001F,
    parameter int                CNT_W     = 32,
    parameter logic [31:0]       NOP_INST  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ifid_write,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    input  logic [31:0]       pc_target,
    input  logic [31:0]       imem_inst,
    output logic [31:0]       pc,
    output logic [31:0]       ifid_pc,
    output logic [31:0]       ifid_inst,
    output logic              ifid_valid,
    output logic [4:0]        ifid_rs1,
    output logic [4:0]        ifid_rs2,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [31:0]       idex_pc,
    output logic [4:0]        idex_rd,
    output logic              idex_valid,
    output logic              idex_memread,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    assign ifid_rs1     = ifid_inst[19:15];
    assign ifid_rs2     = ifid_inst[24:20];
    assign idex_memread = |(idex_ctrl & LOAD_MASK);

    // pipeline registers: reset, then flush redirect, then per-stage hold enables
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
            idex_ctrl  <= '0;
            idex_pc    <= '0;
            idex_rd    <= '0;
            idex_valid <= 1'b0;
        end else if (flush) begin
            pc         <= pc_target & ~32'd3;
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
            idex_ctrl  <= '0;
            idex_pc    <= ifid_pc;
            idex_rd    <= '0;
            idex_valid <= 1'b0;
        end else begin
            if (pc_write)
                pc <= pc + 32'd4;
            if (ifid_write) begin
                ifid_pc    <= pc;
                ifid_inst  <= imem_inst;
                ifid_valid <= 1'b1;
            end
            idex_ctrl  <= ctrl_in;
            idex_pc    <= ifid_pc;
            idex_rd    <= ifid_inst[11:7];
            idex_valid <= ifid_valid & ifid_write & (|ctrl_in);
        end
    end

    // saturating stall/flush performance counters; flush cycles never count as stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush && !(&flush_count))
                flush_count <= flush_count + 1'b1;
            if (!flush && (!pc_write || !ifid_write) && !(&stall_count))
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule
